// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: data width and the opcode encodings
// used by both the opcode decode in the ALU and its testbench.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  typedef enum logic [OP_W-1:0] {
    OP_MOV  = 5'h00,
    OP_MOVL = 5'h02,
    OP_MOVH = 5'h03,
    OP_ADD  = 5'h04,
    OP_SUB  = 5'h05,
    OP_MUL  = 5'h06,
    OP_DIV  = 5'h07,
    OP_AND  = 5'h08,
    OP_OR   = 5'h09,
    OP_NOT  = 5'h0A,
    OP_XOR  = 5'h0B,
    OP_SHL  = 5'h0C,
    OP_SHR  = 5'h0D,
    OP_ASR  = 5'h0E
  } alu_op_e;

endpackage

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider. A zero divisor yields an
// all-ones quotient, the value the ALU reports for division by zero.
module alu_divider
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient
);

  logic [DATA_W:0]   rem;
  logic [DATA_W-1:0] quo;

  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      rem = {rem[DATA_W-1:0], dividend[i]};
      if (rem >= {1'b0, divisor}) begin
        rem    = rem - {1'b0, divisor};
        quo[i] = 1'b1;
      end
    end
  end

  assign quotient = (divisor == '0) ? '1 : quo;

endmodule

// File: rtl/alu.sv
// Single-cycle 32-bit ALU with a registered result. Handshake: is_alu_op
// high at a rising edge loads result and raises result_valid for exactly
// the following cycle; with is_alu_op low the result holds and result_valid
// is 0. There is no backpressure.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [4:0]  aluop,
  input  logic        is_alu_op,
  output logic [31:0] result,
  output logic        result_valid
);

  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] next_result;
  logic [4:0]        shamt;

  alu_divider u_divider (
    .dividend (val1),
    .divisor  (val2),
    .quotient (quotient)
  );

  // Only the low five bits of val2 select the shift distance.
  assign shamt = val2[4:0];

  always_comb begin
    next_result = '0;
    case (aluop)
      OP_MOV:  next_result = val2;
      OP_MOVL: next_result = {16'h0, val2[15:0]};
      OP_MOVH: next_result = {val2[31:16], 16'h0};
      OP_ADD:  next_result = val1 + val2;
      OP_SUB:  next_result = val1 - val2;
      OP_MUL:  next_result = val1 * val2;
      OP_DIV:  next_result = quotient;
      OP_AND:  next_result = val1 & val2;
      OP_OR:   next_result = val1 | val2;
      OP_NOT:  next_result = {31'h0, (val1 == '0)};
      OP_XOR:  next_result = val1 ^ val2;
      OP_SHL:  next_result = val1 << shamt;
      OP_SHR:  next_result = val1 >> shamt;
      OP_ASR:  next_result = $unsigned($signed(val1) >>> shamt);
      default: next_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= is_alu_op;
      if (is_alu_op) begin
        result <= next_result;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the ALU: directed opcode table, hold and
// asynchronous reset sequences, then randomized operations vs. a model.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [4:0]  aluop;
  logic        is_alu_op;
  logic [31:0] result;
  logic        result_valid;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_result;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .val1         (val1),
    .val2         (val2),
    .aluop        (aluop),
    .is_alu_op    (is_alu_op),
    .result       (result),
    .result_valid (result_valid)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: opcode meaning from plain arithmetic
  function automatic logic [31:0] ref_alu(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    logic [63:0] p;
    logic [31:0] fill;
    s = b % 32;
    case (op)
      5'h00: return b;
      5'h02: return b % 32'h0001_0000;
      5'h03: return (b / 32'h0001_0000) * 32'h0001_0000;
      5'h04: return a + b;
      5'h05: return a - b;
      5'h06: begin
        p = {32'h0, a} * {32'h0, b};
        return p[31:0];
      end
      5'h07: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'h08: return a & b;
      5'h09: return a | b;
      5'h0A: return (a == 0) ? 32'd1 : 32'd0;
      5'h0B: return a ^ b;
      5'h0C: return a << s;
      5'h0D: return a >> s;
      5'h0E: begin
        fill = (a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        return (a >> s) | fill;
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one operation per cycle, checked 1 ns after the capturing edge
  task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic en,
                        input logic [31:0] exp, input string name);
    logic [31:0] e;
    @(negedge clk);
    aluop     = op;
    val1      = a;
    val2      = b;
    is_alu_op = en;
    if (en) model_result = exp;
    exp_q.push_back(model_result);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({name, "_result"}, result, e);
    check({name, "_valid"}, {31'h0, result_valid}, {31'h0, en});
  endtask

  initial begin
    vecs.push_back('{OP_MOV,  32'd8, 32'd8, 32'h8});
    vecs.push_back('{OP_MOVL, 32'd8, 32'd8, 32'h8});
    vecs.push_back('{OP_MOVH, 32'd8, 32'd8, 32'h0});
    vecs.push_back('{OP_ADD,  32'd8, 32'd8, 32'h10});
    vecs.push_back('{OP_SUB,  32'd8, 32'd8, 32'h0});
    vecs.push_back('{OP_MUL,  32'd8, 32'd8, 32'h40});
    vecs.push_back('{OP_DIV,  32'd8, 32'd8, 32'h1});
    vecs.push_back('{OP_AND,  32'd8, 32'd8, 32'h8});
    vecs.push_back('{OP_OR,   32'd8, 32'd8, 32'h8});
    vecs.push_back('{OP_NOT,  32'd8, 32'd8, 32'h0});
    vecs.push_back('{OP_XOR,  32'd8, 32'd8, 32'h0});
    vecs.push_back('{OP_SHL,  32'd8, 32'd8, 32'h800});
    vecs.push_back('{OP_SHR,  32'd8, 32'd8, 32'h0});
    vecs.push_back('{OP_ASR,  32'd8, 32'd8, 32'h0});
    vecs.push_back('{OP_ASR,  32'h8000_0000, 32'd4, 32'hF800_0000});
    vecs.push_back('{OP_SHR,  32'h8000_0000, 32'd4, 32'h0800_0000});
    vecs.push_back('{OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF});
    vecs.push_back('{OP_SUB,  32'd0, 32'd1, 32'hFFFF_FFFF});
    vecs.push_back('{OP_MOVH, 32'd0, 32'h1234_5678, 32'h1234_0000});
    vecs.push_back('{OP_MOVL, 32'd0, 32'h1234_5678, 32'h0000_5678});
    vecs.push_back('{OP_NOT,  32'd0, 32'd0, 32'h1});
    vecs.push_back('{OP_SHL,  32'h0000_0003, 32'hFFFF_FFE0, 32'h3});
    vecs.push_back('{OP_ASR,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF});
    vecs.push_back('{5'h01,   32'd8, 32'd8, 32'h0});
    vecs.push_back('{OP_MOV,  32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    vecs.push_back('{5'h1F,   32'd8, 32'd8, 32'h0});

    // reset: asserted with a real falling edge shortly after time 0
    rst_n = 1'b1; val1 = '0; val2 = '0; aluop = '0; is_alu_op = 1'b0;
    model_result = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_result", result, 32'h0);
    check("reset_valid", {31'h0, result_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].v1, vecs[i].v2, 1'b1, vecs[i].exp,
             $sformatf("vec%0d_op%02h", i, vecs[i].op));
    end

    // hold: ADD then disable with new operands
    run_op(OP_ADD, 32'd3, 32'd4, 1'b1, 32'd7, "hold_add");
    run_op(OP_SUB, 32'd100, 32'd200, 1'b0, 32'd0, "hold_idle1");
    run_op(OP_MUL, 32'd9, 32'd9, 1'b0, 32'd0, "hold_idle2");

    // async reset mid-cycle with an operation in flight
    run_op(OP_MOV, 32'd0, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A, "pre_reset");
    @(negedge clk);
    aluop = OP_ADD; val1 = 32'd1; val2 = 32'd2; is_alu_op = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_result", result, 32'h0);
    check("async_rst_valid", {31'h0, result_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("in_rst_result", result, 32'h0);
    check("in_rst_valid", {31'h0, result_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    is_alu_op = 1'b0;
    model_result = '0;
    @(posedge clk);
    #1;
    check("post_rst_result", result, 32'h0);
    check("post_rst_valid", {31'h0, result_valid}, 32'h0);

    // randomized operations against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        en;
      op = 5'($urandom_range(0, 31));
      en = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      if (op >= OP_SHL && op <= OP_ASR && $urandom_range(0, 1) == 1)
        a = a | 32'h8000_0000;
      run_op(op, a, b, en, ref_alu(op, a, b), $sformatf("rand%0d_op%02h", n, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The port list SHALL be, one per line: name, direction, width, meaning; clock and reset first.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 val1  input  32  first operand.
REQ-005 val2  input  32  second operand, or shift amount.
REQ-006 aluop  input  5  operation select (encodings in REQ-011).
REQ-007 is_alu_op  input  1  operation enable; high means the current aluop is a valid ALU operation.
REQ-008 result  output  32  registered operation result.
REQ-009 result_valid  output  1  high for one cycle after each enabled operation.
REQ-010 The block SHALL have no parameters; data width is fixed at 32.

Function
REQ-011 Opcode encodings: MOV=0x00, MOVL=0x02, MOVH=0x03, ADD=0x04, SUB=0x05, MUL=0x06, DIV=0x07, AND=0x08, OR=0x09, NOT=0x0A, XOR=0x0B, SHL=0x0C, SHR=0x0D, ASR=0x0E.
REQ-012 Latency: when is_alu_op=1 at a rising clk edge, result SHALL take the computed value at that edge and result_valid SHALL be 1 for that cycle.
REQ-013 When is_alu_op=0 at a rising clk edge, result SHALL hold its value and result_valid SHALL be 0.
REQ-014 MOV: result = val2.
REQ-015 MOVL: result = {16'h0, val2[15:0]}.
REQ-016 MOVH: result = {val2[31:16], 16'h0}.
REQ-017 ADD: result = val1+val2 mod 2^32. SUB: result = val1-val2 mod 2^32 (wraps, no flags).
REQ-018 MUL: result = low 32 bits of the unsigned product val1*val2.
REQ-019 DIV: result = unsigned quotient val1/val2; when val2=0, result SHALL be 0xFFFFFFFF.
REQ-020 AND, OR and XOR: bitwise operations on val1 and val2.
REQ-021 NOT: logical not of val1; result = 1 when val1==0, otherwise 0.
REQ-022 SHL: result = val1 << val2[4:0]. SHR: logical right shift by val2[4:0].
REQ-023 ASR: arithmetic right shift of val1 by val2[4:0], filling vacated bits with val1[31].
REQ-024 Shift amounts: val2[31:5] SHALL be ignored; shift by 0 returns val1 unchanged.
REQ-025 Undefined opcodes (0x01, 0x0F–0x1F) with is_alu_op=1 SHALL load result=0 and assert result_valid.

Reset
REQ-026 rst_n low SHALL immediately and asynchronously force result=0 and result_valid=0.
REQ-027 Outputs SHALL stay at 0 while rst_n is low; the first update is at the first rising clk edge after rst_n deasserts.
REQ-028 An operation in flight when reset asserts SHALL be discarded.

Structure
REQ-029 The opcode constants (REQ-011) SHALL live in the shared defines package and be used by both the decoder and the ALU.
REQ-030 Combinational compute logic and the output register SHALL be in one module; a sub-module alu_divider (combinational unsigned divider, including the divide-by-zero rule) is natural.

Verification
REQ-031 Bench SHALL apply val1=8, val2=8, is_alu_op=1 and step through all opcodes; required results: MOV 0x8, MOVL 0x8, MOVH 0x0, ADD 0x10, SUB 0x0, MUL 0x40, DIV 0x1, AND 0x8, OR 0x8, NOT 0x0, XOR 0x0, SHL 0x800, SHR 0x0, ASR 0x0.
REQ-032 Bench SHALL apply ASR with val1=0x80000000, val2=4 and require result=0xF8000000; SHR with the same operands SHALL give 0x08000000.
REQ-033 Bench SHALL apply DIV with val1=5, val2=0 and require result=0xFFFFFFFF; SUB with val1=0, val2=1 SHALL give 0xFFFFFFFF.
REQ-034 Bench SHALL apply MOVH with val2=0x12345678 and require result=0x12340000; MOVL with the same val2 SHALL give 0x00005678.
REQ-035 Bench SHALL run ADD, then drop is_alu_op to 0 and change the operands; result SHALL hold its value and result_valid SHALL be 0.
REQ-036 Bench SHALL assert rst_n low between clock edges; result and result_valid SHALL go to 0 at once, without waiting for a clock edge.
